uart_cmd_decoder: RTL

//  Consumes bytes from the UART receiver and turns ASCII commands into control for the up/down counter.

---
 rtl/uart_cmd_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: buffers received UART bytes and decodes ASCII commands into counter control
//
// Ports
//    clk        in   1  system clock
//    rst        in   1  asynchronous active-low reset
//    rx_data    in   8  received byte, valid while rx_done=1
//    rx_done    in   1  one-cycle byte strobe from uart_rx
//    tx_busy    in   1  uart_tx busy flag (used only with echo)
//    cmd_run    out  1  level: counter running
//    cmd_mode   out  1  level: 0 = count up, 1 = count down
//    cmd_clear  out  1  one-cycle clear pulse
//    cmd_err    out  1  one-cycle pulse for an unrecognised byte
//    overflow   out  1  sticky: a byte was dropped on a full FIFO
//    tx_start   out  1  one-cycle echo strobe
//    tx_data    out  8  echo byte, held until the next echo
//
// Macro CMD_ECHO_EN: when defined, every decoded byte is echoed to uart_tx
// through the ECHO/GUARD states; otherwise tx_start/tx_data are tied to 0.
module uart_cmd_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       tx_busy,
   output logic       cmd_run,
   output logic       cmd_mode,
   output logic       cmd_clear,
   output logic       cmd_err,
   output logic       overflow,
   output logic       tx_start,
   output logic [7:0] tx_data
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, ECHO, GUARD} state_t;
   state_t state, state_d;
   logic [7:0] mem [FIFO_DEPTH];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic [7:0] cmd_byte, cmd_byte_d, ucase;
   logic empty, full, pop, push;
   logic run_d, mode_d, clear_d, err_d;
   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};
   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   // FETCH is only entered with a non-empty FIFO, so a pop there is always valid.
   assign pop  = state == FETCH;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign push = rx_done && (!full || pop);
   // Fold lowercase letters onto uppercase; everything else passes unchanged.
   assign ucase = (cmd_byte >= 8'h61 && cmd_byte <= 8'h7A) ? cmd_byte - 8'h20 : cmd_byte;
`ifdef CMD_ECHO_EN
   logic       start_d;
   logic [7:0] data_d;
`else
   logic unused_tx_busy;
   assign unused_tx_busy = tx_busy;
   assign tx_start = 1'b0;
   assign tx_data  = 8'h00;
`endif
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= rx_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_byte  <= 8'h00;
         cmd_run   <= 1'b0;
         cmd_mode  <= 1'b0;
         cmd_clear <= 1'b0;
         cmd_err   <= 1'b0;
         overflow  <= 1'b0;
`ifdef CMD_ECHO_EN
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
`endif
      end else begin
         state     <= state_d;
         cmd_byte  <= cmd_byte_d;
         cmd_run   <= run_d;
         cmd_mode  <= mode_d;
         cmd_clear <= clear_d;
         cmd_err   <= err_d;
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (rx_done && !push) overflow <= 1'b1;
`ifdef CMD_ECHO_EN
         tx_start  <= start_d;
         tx_data   <= data_d;
`endif
      end
   always_comb begin
      state_d    = state;
      cmd_byte_d = cmd_byte;
      run_d      = cmd_run;
      mode_d     = cmd_mode;
      clear_d    = 1'b0;
      err_d      = 1'b0;
`ifdef CMD_ECHO_EN
      start_d    = 1'b0;
      data_d     = tx_data;
`endif
      case (state)
         IDLE:  state_d = empty ? IDLE : FETCH;
         FETCH: begin
            cmd_byte_d = mem[rd_ptr[FIFO_AW-1:0]];
            state_d    = EXEC;
         end
         EXEC: begin
            case (ucase)
               8'h52:   run_d   = 1'b1;
               8'h53:   run_d   = 1'b0;
               8'h43:   clear_d = 1'b1;
               8'h4D:   mode_d  = !cmd_mode;
               8'h55:   mode_d  = 1'b0;
               8'h44:   mode_d  = 1'b1;
               default: err_d   = 1'b1;
            endcase
`ifdef CMD_ECHO_EN
            state_d = ECHO;
`else
            state_d = IDLE;
`endif
         end
`ifdef CMD_ECHO_EN
         ECHO:
            if (!tx_busy) begin
               start_d = 1'b1;
               data_d  = cmd_byte;
               state_d = GUARD;
            end
         // One idle cycle lets uart_tx raise tx_busy before the next echo.
         GUARD: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end
endmodule
